// File: rtl/backprop_accumulator_if.sv
// Stream bundle for backprop_accumulator: contribution input, sum output.
// acc_clipped exists only when BPA_CLIP_EN is defined.
interface backprop_accumulator_if #(
  parameter int CNT_W = 3
);
  real              acc_in;
  logic             acc_in_valid;
  logic             acc_in_ready;
  real              acc_out;
  logic             acc_out_valid;
  logic             acc_out_ready;
  logic [CNT_W-1:0] acc_count;
`ifdef BPA_CLIP_EN
  logic             acc_clipped;
`endif

  modport master (
    output acc_in, acc_in_valid, acc_out_ready,
    input  acc_in_ready, acc_out, acc_out_valid, acc_count
`ifdef BPA_CLIP_EN
    , input acc_clipped
`endif
  );

  modport slave (
    input  acc_in, acc_in_valid, acc_out_ready,
    output acc_in_ready, acc_out, acc_out_valid, acc_count
`ifdef BPA_CLIP_EN
    , output acc_clipped
`endif
  );
endinterface

// File: rtl/backprop_accumulator.sv
// Sums N_INPUTS back-prop contributions into one held error term.
// Optional output clamp to +/-CLIP_LIMIT enabled by BPA_CLIP_EN.
module backprop_accumulator #(
  parameter int  N_INPUTS   = 4,
  parameter int  CNT_W      = $clog2(N_INPUTS + 1),
  parameter real CLIP_LIMIT = 1.0
) (
  input logic clk,
  input logic rst,
  input logic acc_clear,
  backprop_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  if (N_INPUTS < 1 || CLIP_LIMIT < 0.0) begin : g_bad_cfg
    $error("backprop_accumulator: bad N_INPUTS or CLIP_LIMIT");
  end

  state_e           state_q, state_d;
  real              sum_q, sum_d;
  real              out_q, out_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy;
  logic             accept;
  real              fin;
`ifdef BPA_CLIP_EN
  logic             clp_q, clp_d;
`endif

  assign rdy    = !rst && (state_q == S_IDLE || state_q == S_ACCUM);
  assign accept = bus.acc_in_valid && rdy;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    out_d   = out_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
`ifdef BPA_CLIP_EN
    clp_d   = clp_q;
`endif
    fin = (state_q == S_IDLE) ? bus.acc_in : sum_q + bus.acc_in;
    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          sum_d = fin;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            vld_d   = 1'b1;
`ifdef BPA_CLIP_EN
            clp_d = 1'b1;
            if (fin > CLIP_LIMIT) out_d = CLIP_LIMIT;
            else if (fin < -CLIP_LIMIT) out_d = -CLIP_LIMIT;
            else begin
              out_d = fin;
              clp_d = 1'b0;
            end
`else
            out_d = fin;
`endif
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_DONE: begin
        if (vld_q && bus.acc_out_ready) begin
          state_d = S_IDLE;
          sum_d   = 0.0;
          cnt_d   = '0;
          vld_d   = 1'b0;
`ifdef BPA_CLIP_EN
          clp_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything; acc_out keeps its last value.
    if (acc_clear) begin
      state_d = S_IDLE;
      sum_d   = 0.0;
      cnt_d   = '0;
      vld_d   = 1'b0;
`ifdef BPA_CLIP_EN
      clp_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sum_q   <= 0.0;
      out_q   <= 0.0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef BPA_CLIP_EN
      clp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
`ifdef BPA_CLIP_EN
      clp_q   <= clp_d;
`endif
    end
  end

  assign bus.acc_in_ready  = rdy;
  assign bus.acc_out       = out_q;
  assign bus.acc_out_valid = vld_q;
  assign bus.acc_count     = cnt_q;
`ifdef BPA_CLIP_EN
  assign bus.acc_clipped   = clp_q;
`endif

endmodule

// File: tb/tb_backprop_accumulator.sv
// Directed bench for backprop_accumulator (N=4 and N=1 instances).
// Expected sums account for the clamp when BPA_CLIP_EN is defined.
module tb_backprop_accumulator;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  backprop_accumulator_if #(.CNT_W(3)) if0 ();
  backprop_accumulator_if #(.CNT_W(1)) if1 ();

  backprop_accumulator #(.N_INPUTS(4), .CLIP_LIMIT(1.0)) u0 (
    .clk(clk), .rst(rst), .acc_clear(clr), .bus(if0.slave)
  );

  backprop_accumulator #(.N_INPUTS(1), .CLIP_LIMIT(1.0)) u1 (
    .clk(clk), .rst(rst), .acc_clear(clr), .bus(if1.slave)
  );

  function automatic real exp_v(real v);
`ifdef BPA_CLIP_EN
    if (v > 1.0) return 1.0;
    if (v < -1.0) return -1.0;
`endif
    return v;
  endfunction

  task automatic beat(real v);
    if0.acc_in       = v;
    if0.acc_in_valid = 1'b1;
    @(posedge clk); #1;
    if0.acc_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b0;
    if0.acc_in = 0.0; if0.acc_in_valid = 1'b0; if0.acc_out_ready = 1'b1;
    if1.acc_in = 0.0; if1.acc_in_valid = 1'b0; if1.acc_out_ready = 1'b1;
    #2;
    checks++;
    if (if0.acc_in_ready !== 1'b0 || if0.acc_out_valid !== 1'b0 ||
        if0.acc_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctl: rdy=%b vld=%b cnt=%0d want 0/0/0",
               if0.acc_in_ready, if0.acc_out_valid, if0.acc_count);
    end
    checks++;
    if (if0.acc_out != 0.0) begin
      errors++;
      $display("FAIL reset_out: got %f want 0.0", if0.acc_out);
    end
`ifdef BPA_CLIP_EN
    checks++;
    if (if0.acc_clipped !== 1'b0) begin
      errors++;
      $display("FAIL reset_clip: got %b want 0", if0.acc_clipped);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (if0.acc_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_after: got %b want 1", if0.acc_in_ready);
    end
  endtask

  task automatic test_basic_sum();
    real vals[4] = '{0.5, -0.25, 0.125, 0.0};
    if0.acc_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if0.acc_in_ready !== 1'b1 || if0.acc_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_pre%0d: rdy=%b vld=%b want 1/0",
                 i, if0.acc_in_ready, if0.acc_out_valid);
      end
      beat(vals[i]);
      checks++;
      if (if0.acc_count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL basic_cnt%0d: got %0d want %0d", i, if0.acc_count, i + 1);
      end
    end
    checks++;
    if (if0.acc_out_valid !== 1'b1 || if0.acc_out != 0.375 ||
        if0.acc_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: vld=%b out=%f rdy=%b want 1/0.375/0",
               if0.acc_out_valid, if0.acc_out, if0.acc_in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (if0.acc_out_valid !== 1'b0 || if0.acc_count !== 3'd0 ||
        if0.acc_out != 0.375 || if0.acc_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: vld=%b cnt=%0d out=%f rdy=%b want 0/0/0.375/1",
               if0.acc_out_valid, if0.acc_count, if0.acc_out, if0.acc_in_ready);
    end
  endtask

  task automatic test_stall();
    if0.acc_out_ready = 1'b0;
    beat(1.0); beat(2.0); beat(3.0); beat(4.0);
    if0.acc_in       = 100.0;
    if0.acc_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (if0.acc_out_valid !== 1'b1 || if0.acc_out != exp_v(10.0) ||
          if0.acc_count !== 3'd4 || if0.acc_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: vld=%b out=%f cnt=%0d rdy=%b want 1/%f/4/0",
                 i, if0.acc_out_valid, if0.acc_out, if0.acc_count,
                 if0.acc_in_ready, exp_v(10.0));
      end
    end
    if0.acc_in_valid  = 1'b0;
    if0.acc_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if0.acc_out_valid !== 1'b0 || if0.acc_count !== 3'd0) begin
      errors++;
      $display("FAIL stall_drain: vld=%b cnt=%0d want 0/0",
               if0.acc_out_valid, if0.acc_count);
    end
  endtask

  task automatic test_clear();
    beat(1.0); beat(2.0);
    checks++;
    if (if0.acc_count !== 3'd2) begin
      errors++;
      $display("FAIL clear_pre: cnt=%0d want 2", if0.acc_count);
    end
    clr = 1'b1;
    if0.acc_in = 50.0;
    if0.acc_in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    if0.acc_in_valid = 1'b0;
    checks++;
    if (if0.acc_count !== 3'd0 || if0.acc_out_valid !== 1'b0 ||
        if0.acc_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_post: cnt=%0d vld=%b rdy=%b want 0/0/1",
               if0.acc_count, if0.acc_out_valid, if0.acc_in_ready);
    end
    beat(1.0);
    checks++;
    if (if0.acc_count !== 3'd1) begin
      errors++;
      $display("FAIL clear_restart: cnt=%0d want 1", if0.acc_count);
    end
    beat(1.0); beat(1.0); beat(1.0);
    checks++;
    if (if0.acc_out_valid !== 1'b1 || if0.acc_out != exp_v(4.0)) begin
      errors++;
      $display("FAIL clear_sum: vld=%b out=%f want 1/%f",
               if0.acc_out_valid, if0.acc_out, exp_v(4.0));
    end
    @(posedge clk); #1;
    if0.acc_out_ready = 1'b0;
    beat(0.25); beat(0.25); beat(0.25); beat(0.25);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (if0.acc_out_valid !== 1'b0 || if0.acc_count !== 3'd0 ||
        if0.acc_out != 1.0) begin
      errors++;
      $display("FAIL clear_done: vld=%b cnt=%0d out=%f want 0/0/1.0",
               if0.acc_out_valid, if0.acc_count, if0.acc_out);
    end
    if0.acc_out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    beat(0.5); beat(0.5);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (if0.acc_count !== 3'd0 || if0.acc_out != 0.0 ||
        if0.acc_in_ready !== 1'b0 || if0.acc_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: cnt=%0d out=%f rdy=%b vld=%b want 0/0.0/0/0",
               if0.acc_count, if0.acc_out, if0.acc_in_ready, if0.acc_out_valid);
    end
    #2;
    rst = 1'b0;
    beat(0.5); beat(0.5); beat(-0.25); beat(0.75);
    checks++;
    if (if0.acc_out_valid !== 1'b1 || if0.acc_out != exp_v(1.5) ||
        if0.acc_count !== 3'd4) begin
      errors++;
      $display("FAIL async_sum: vld=%b out=%f cnt=%0d want 1/%f/4",
               if0.acc_out_valid, if0.acc_out, if0.acc_count, exp_v(1.5));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_n1();
    if1.acc_out_ready = 1'b1;
    if1.acc_in        = -3.5;
    if1.acc_in_valid  = 1'b1;
    #1;
    checks++;
    if (if1.acc_in_ready !== 1'b1 || if1.acc_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL n1_pre: rdy=%b vld=%b want 1/0",
               if1.acc_in_ready, if1.acc_out_valid);
    end
    @(posedge clk); #1;
    if1.acc_in_valid = 1'b0;
    checks++;
    if (if1.acc_out_valid !== 1'b1 || if1.acc_out != exp_v(-3.5) ||
        if1.acc_count !== 1'b1 || if1.acc_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL n1_done: vld=%b out=%f cnt=%0d rdy=%b want 1/%f/1/0",
               if1.acc_out_valid, if1.acc_out, if1.acc_count,
               if1.acc_in_ready, exp_v(-3.5));
    end
    @(posedge clk); #1;
    checks++;
    if (if1.acc_out_valid !== 1'b0 || if1.acc_count !== 1'b0) begin
      errors++;
      $display("FAIL n1_drain: vld=%b cnt=%0d want 0/0",
               if1.acc_out_valid, if1.acc_count);
    end
  endtask

  task automatic test_clip_bound();
    beat(0.75); beat(0.75); beat(0.0); beat(0.0);
    checks++;
    if (if0.acc_out_valid !== 1'b1 || if0.acc_out != exp_v(1.5)) begin
      errors++;
      $display("FAIL clip_hi: vld=%b out=%f want 1/%f",
               if0.acc_out_valid, if0.acc_out, exp_v(1.5));
    end
`ifdef BPA_CLIP_EN
    checks++;
    if (if0.acc_clipped !== 1'b1) begin
      errors++;
      $display("FAIL clip_hi_flag: got %b want 1", if0.acc_clipped);
    end
`endif
    @(posedge clk); #1;
`ifdef BPA_CLIP_EN
    checks++;
    if (if0.acc_clipped !== 1'b0) begin
      errors++;
      $display("FAIL clip_flag_drop: got %b want 0", if0.acc_clipped);
    end
`endif
    beat(-0.5); beat(0.0); beat(0.0); beat(0.0);
    checks++;
    if (if0.acc_out_valid !== 1'b1 || if0.acc_out != -0.5) begin
      errors++;
      $display("FAIL clip_in: vld=%b out=%f want 1/-0.5",
               if0.acc_out_valid, if0.acc_out);
    end
`ifdef BPA_CLIP_EN
    checks++;
    if (if0.acc_clipped !== 1'b0) begin
      errors++;
      $display("FAIL clip_in_flag: got %b want 0", if0.acc_clipped);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_stall();
    test_clear();
    test_async_reset();
    test_n1();
    test_clip_bound();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
